// File: rtl/cache_store_merge.sv
// Read-modify-write store merger: reads one 4-way cache set, merges a byte-enabled
// 32-bit store into the selected way, writes the set back. Macro CACHE_ST_FWD_EN selects forwarding.
module cache_store_merge #(
    parameter int CL_SIZE = 512,
    parameter int IDX_CNT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    // Store request: valid/ready handshake; a request transfers on a rising edge
    // where st_valid && st_ready; the requestor holds all st_* fields until then.
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [IDX_CNT-1:0]            st_idx,
    input  logic [1:0]                    st_way,
    input  logic [$clog2(CL_SIZE/8)-1:0]  st_offset,
    input  logic [31:0]                   st_data,
    input  logic [3:0]                    st_be,
    input  logic [2:0]                    ext_rd_op,
    input  logic [IDX_CNT-1:0]            ext_rd_idx,
    output logic [2:0]                    ds_operation,
    output logic [IDX_CNT-1:0]            ds_idx,
    input  logic [CL_SIZE*4-1:0]          cl_lines_in,
    output logic [CL_SIZE*4-1:0]          cl_in_wb,
    output logic [IDX_CNT-1:0]            idx_in_wb,
    output logic                          alloc,
    output logic                          st_fwd,
    output logic                          ext_stall,
    output logic                          hazard_stall,
    output logic                          st_done,
    output logic [1:0]                    dbg_state
);

    localparam int OFF_W = $clog2(CL_SIZE/8);
    localparam int LW    = CL_SIZE*4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               st_ready_q, st_ready_d;
    logic               alloc_q, alloc_d;
    logic               st_done_q, st_done_d;
    logic [IDX_CNT-1:0] idx_q, idx_d;
    logic [1:0]         way_q, way_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         be_q, be_d;
    logic [LW-1:0]      cl_in_wb_q, cl_in_wb_d;
    logic [IDX_CNT-1:0] idx_in_wb_q, idx_in_wb_d;

    logic [LW-1:0]      merged;
    int                 bit_base;
    logic               fwd_hit;

    // Byte-wise overlay of the registered store onto the line read back in WAIT.
    always_comb begin
        merged   = cl_lines_in;
        bit_base = int'(way_q) * CL_SIZE + int'(off_q) * 8;
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) begin
                merged[bit_base + k*8 +: 8] = data_q[k*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        st_ready_d  = 1'b0;
        alloc_d     = 1'b0;
        st_done_d   = 1'b0;
        idx_d       = idx_q;
        way_d       = way_q;
        off_d       = off_q;
        data_d      = data_q;
        be_d        = be_q;
        cl_in_wb_d  = cl_in_wb_q;
        idx_in_wb_d = idx_in_wb_q;
        case (state_q)
            IDLE: begin
                if (st_valid && st_ready_q) begin
                    state_d = READ;
                    idx_d   = st_idx;
                    way_d   = st_way;
                    off_d   = st_offset & ~OFF_W'(3);
                    data_d  = st_data;
                    be_d    = st_be;
                end else begin
                    st_ready_d = 1'b1;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                state_d     = WRITE;
                alloc_d     = 1'b1;
                st_done_d   = 1'b1;
                cl_in_wb_d  = merged;
                idx_in_wb_d = idx_q;
            end
            WRITE: begin
                state_d    = IDLE;
                st_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            st_ready_q  <= 1'b0;
            alloc_q     <= 1'b0;
            st_done_q   <= 1'b0;
            idx_q       <= '0;
            way_q       <= '0;
            off_q       <= '0;
            data_q      <= '0;
            be_q        <= '0;
            cl_in_wb_q  <= '0;
            idx_in_wb_q <= '0;
        end else begin
            state_q     <= state_d;
            st_ready_q  <= st_ready_d;
            alloc_q     <= alloc_d;
            st_done_q   <= st_done_d;
            idx_q       <= idx_d;
            way_q       <= way_d;
            off_q       <= off_d;
            data_q      <= data_d;
            be_q        <= be_d;
            cl_in_wb_q  <= cl_in_wb_d;
            idx_in_wb_q <= idx_in_wb_d;
        end
    end

    // The data-store read port belongs to the pipeline except while this block reads the set.
    assign ds_operation = !rst ? 3'b000 : (state_q == READ) ? 3'b010 : ext_rd_op;
    assign ds_idx       = (rst && state_q == READ) ? idx_q : ext_rd_idx;
    assign ext_stall    = rst && (state_q == READ);
    assign st_ready     = rst && st_ready_q;
    assign alloc        = rst && alloc_q;
    assign st_done      = rst && st_done_q;
    assign cl_in_wb     = cl_in_wb_q;
    assign idx_in_wb    = idx_in_wb_q;
    assign dbg_state    = state_q;

    // A pipeline read of the set being written back this cycle would see stale data.
    assign fwd_hit = rst && alloc_q && (ext_rd_op != 3'b000) && (ext_rd_idx == idx_in_wb_q);

`ifdef CACHE_ST_FWD_EN
    assign st_fwd       = fwd_hit;
    assign hazard_stall = 1'b0;
`else
    assign st_fwd       = 1'b0;
    assign hazard_stall = fwd_hit;
`endif

endmodule

// File: tb/tb_cache_store_merge.sv
// Directed self-checking bench for cache_store_merge: handshake timing, byte merge,
// read-port arbitration, writeback hazard/forward flag and reset abort.
module tb_cache_store_merge;

    localparam int CL = 512;
    localparam int IW = 8;
    localparam int LW = CL*4;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [IW-1:0] st_idx;
    logic [1:0]    st_way;
    logic [5:0]    st_offset;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [2:0]    ext_rd_op;
    logic [IW-1:0] ext_rd_idx;
    logic [2:0]    ds_operation;
    logic [IW-1:0] ds_idx;
    logic [LW-1:0] cl_lines_in;
    logic [LW-1:0] cl_in_wb;
    logic [IW-1:0] idx_in_wb;
    logic          alloc;
    logic          st_fwd;
    logic          ext_stall;
    logic          hazard_stall;
    logic          st_done;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_store_merge #(.CL_SIZE(CL), .IDX_CNT(IW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_idx(st_idx), .st_way(st_way),
        .st_offset(st_offset), .st_data(st_data), .st_be(st_be),
        .ext_rd_op(ext_rd_op), .ext_rd_idx(ext_rd_idx),
        .ds_operation(ds_operation), .ds_idx(ds_idx),
        .cl_lines_in(cl_lines_in), .cl_in_wb(cl_in_wb), .idx_in_wb(idx_in_wb),
        .alloc(alloc), .st_fwd(st_fwd), .ext_stall(ext_stall),
        .hazard_stall(hazard_stall), .st_done(st_done), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Full store sequence with checks in every state; expected line is built by the caller.
    task automatic run_store(input string name, input logic [IW-1:0] idx, input logic [1:0] way,
                             input logic [5:0] off, input logic [31:0] data, input logic [3:0] be,
                             input logic [LW-1:0] exp_line);
        int   waited;
        logic hit;
        st_idx = idx; st_way = way; st_offset = off; st_data = data; st_be = be;
        st_valid = 1'b1;
        waited = 0;
        while (st_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        total++;
        if (st_ready !== 1'b1) begin
            bad++; $display("FAIL %s accept_timeout st_ready=%b required=1", name, st_ready);
            st_valid = 1'b0;
            return;
        end
        tick();
        st_valid = 1'b0;
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL %s read_ready got=%b exp=0", name, st_ready); end
        total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL %s read_state got=%0d exp=1", name, dbg_state); end
        total++; if (ext_stall !== 1'b1) begin bad++; $display("FAIL %s read_stall got=%b exp=1", name, ext_stall); end
        total++; if (ds_operation !== 3'b010) begin bad++; $display("FAIL %s read_op got=%b exp=010", name, ds_operation); end
        total++; if (ds_idx !== idx) begin bad++; $display("FAIL %s read_idx got=%h exp=%h", name, ds_idx, idx); end
        total++; if (alloc !== 1'b0) begin bad++; $display("FAIL %s read_alloc got=%b exp=0", name, alloc); end
        tick();
        total++; if (ext_stall !== 1'b0) begin bad++; $display("FAIL %s wait_stall got=%b exp=0", name, ext_stall); end
        total++; if (ds_operation !== ext_rd_op) begin bad++; $display("FAIL %s wait_op got=%b exp=%b", name, ds_operation, ext_rd_op); end
        total++; if (ds_idx !== ext_rd_idx) begin bad++; $display("FAIL %s wait_idx got=%h exp=%h", name, ds_idx, ext_rd_idx); end
        total++; if (alloc !== 1'b0 || st_done !== 1'b0) begin bad++; $display("FAIL %s wait_alloc got=%b/%b exp=0/0", name, alloc, st_done); end
        total++; if (st_fwd !== 1'b0 || hazard_stall !== 1'b0) begin bad++; $display("FAIL %s wait_fwd got=%b/%b exp=0/0", name, st_fwd, hazard_stall); end
        tick();
        hit = (ext_rd_op != 3'b000) && (ext_rd_idx == idx);
        total++; if (alloc !== 1'b1) begin bad++; $display("FAIL %s write_alloc got=%b exp=1", name, alloc); end
        total++; if (st_done !== 1'b1) begin bad++; $display("FAIL %s write_done got=%b exp=1", name, st_done); end
        total++; if (idx_in_wb !== idx) begin bad++; $display("FAIL %s write_idx got=%h exp=%h", name, idx_in_wb, idx); end
        total++; if (cl_in_wb !== exp_line) begin bad++; $display("FAIL %s write_line differing_bits=%0d exp=0", name, $countones(cl_in_wb ^ exp_line)); end
`ifdef CACHE_ST_FWD_EN
        total++; if (st_fwd !== hit || hazard_stall !== 1'b0) begin bad++; $display("FAIL %s write_fwd got=%b/%b exp=%b/0", name, st_fwd, hazard_stall, hit); end
`else
        total++; if (st_fwd !== 1'b0 || hazard_stall !== hit) begin bad++; $display("FAIL %s write_hazard got=%b/%b exp=0/%b", name, st_fwd, hazard_stall, hit); end
`endif
        tick();
        total++; if (alloc !== 1'b0 || st_done !== 1'b0) begin bad++; $display("FAIL %s idle_alloc got=%b/%b exp=0/0", name, alloc, st_done); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b exp=1", name, st_ready); end
        total++; if (cl_in_wb !== exp_line || idx_in_wb !== idx) begin bad++; $display("FAIL %s idle_hold differing_bits=%0d idx=%h exp_idx=%h", name, $countones(cl_in_wb ^ exp_line), idx_in_wb, idx); end
        total++; if (st_fwd !== 1'b0 || hazard_stall !== 1'b0) begin bad++; $display("FAIL %s idle_fwd got=%b/%b exp=0/0", name, st_fwd, hazard_stall); end
    endtask

    task automatic test_reset();
        rst = 1'b0; st_valid = 1'b1; st_idx = 8'h12; st_way = 2'd1; st_offset = 6'd4;
        st_data = 32'hFFFF_FFFF; st_be = 4'hF; ext_rd_op = 3'd5; ext_rd_idx = 8'h21; cl_lines_in = '1;
        tick(); tick();
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", st_ready); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        total++; if (alloc !== 1'b0 || st_done !== 1'b0 || ext_stall !== 1'b0) begin bad++; $display("FAIL reset_ctrl got=%b%b%b exp=000", alloc, st_done, ext_stall); end
        total++; if (st_fwd !== 1'b0 || hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b/%b exp=0/0", st_fwd, hazard_stall); end
        total++; if (cl_in_wb !== '0 || idx_in_wb !== '0) begin bad++; $display("FAIL reset_wb bits=%0d idx=%h exp=0", $countones(cl_in_wb), idx_in_wb); end
        total++; if (ds_operation !== 3'b000) begin bad++; $display("FAIL reset_op got=%b exp=000", ds_operation); end
        total++; if (ds_idx !== 8'h21) begin bad++; $display("FAIL reset_ds_idx got=%h exp=21", ds_idx); end
        rst = 1'b1; st_valid = 1'b0;
        tick();
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", st_ready); end
        total++; if (ds_operation !== 3'd5 || ds_idx !== 8'h21) begin bad++; $display("FAIL release_pass got=%b/%h exp=101/21", ds_operation, ds_idx); end
        total++; if (ext_stall !== 1'b0) begin bad++; $display("FAIL release_stall got=%b exp=0", ext_stall); end
        ext_rd_op = 3'd0; ext_rd_idx = 8'h00;
    endtask

    task automatic test_basic();
        logic [LW-1:0] exp;
        cl_lines_in = '0; ext_rd_op = 3'd0; ext_rd_idx = 8'h00;
        exp = '0;
        exp[1088 +: 32] = 32'hDEAD_BEEF;
        run_store("basic", 8'd3, 2'd2, 6'd8, 32'hDEAD_BEEF, 4'hF, exp);
    endtask

    task automatic test_byte_enable();
        logic [LW-1:0] exp;
        cl_lines_in = '1; ext_rd_op = 3'd1; ext_rd_idx = 8'h77;
        exp = '1;
        exp[7:0]   = 8'h00;
        exp[23:16] = 8'h00;
        run_store("be_0101", 8'h10, 2'd0, 6'd0, 32'h0000_0000, 4'b0101, exp);
    endtask

    task automatic test_be_zero();
        logic [LW-1:0] exp;
        cl_lines_in = {64{32'h1357_9BDF}}; ext_rd_op = 3'd0; ext_rd_idx = 8'h09;
        exp = {64{32'h1357_9BDF}};
        run_store("be_zero", 8'h09, 2'd1, 6'd20, 32'hFFFF_FFFF, 4'b0000, exp);
    endtask

    task automatic test_ext_stall();
        logic [LW-1:0] exp;
        cl_lines_in = '0; ext_rd_op = 3'd2; ext_rd_idx = 8'd5;
        exp = '0;
        exp[1536 +: 8] = 8'hA1;
        run_store("ext_stall", 8'h44, 2'd3, 6'd0, 32'h0000_00A1, 4'b0001, exp);
    endtask

    // Offset 2 is word-aligned down to 0; the pipeline reads the same set during WRITE.
    task automatic test_fwd();
        logic [LW-1:0] exp;
        cl_lines_in = '0; ext_rd_op = 3'd1; ext_rd_idx = 8'h3C;
        exp = '0;
        exp[512 +: 32] = 32'h1122_3344;
        run_store("fwd_hit", 8'h3C, 2'd1, 6'd2, 32'h1122_3344, 4'hF, exp);
        ext_rd_op = 3'd0; ext_rd_idx = 8'h00;
    endtask

    task automatic test_reset_in_wait();
        logic [LW-1:0] exp;
        cl_lines_in = '0; ext_rd_op = 3'd0; ext_rd_idx = 8'h00;
        st_idx = 8'h55; st_way = 2'd0; st_offset = 6'd12; st_data = 32'h0BAD_F00D; st_be = 4'hF;
        st_valid = 1'b1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL abort_pre_ready got=%b exp=1", st_ready); end
        tick();
        st_valid = 1'b0;
        tick();
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL abort_in_wait got=%0d exp=2", dbg_state); end
        rst = 1'b0;
        tick();
        total++; if (alloc !== 1'b0 || st_done !== 1'b0) begin bad++; $display("FAIL abort_alloc got=%b/%b exp=0/0", alloc, st_done); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", st_ready); end
        total++; if (cl_in_wb !== '0 || idx_in_wb !== '0) begin bad++; $display("FAIL abort_wb bits=%0d idx=%h exp=0", $countones(cl_in_wb), idx_in_wb); end
        rst = 1'b1;
        tick();
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL abort_release_ready got=%b exp=1", st_ready); end
        total++; if (alloc !== 1'b0) begin bad++; $display("FAIL abort_release_alloc got=%b exp=0", alloc); end
        tick();
        total++; if (alloc !== 1'b0 || idx_in_wb !== '0) begin bad++; $display("FAIL abort_late_alloc got=%b idx=%h exp=0/00", alloc, idx_in_wb); end
        exp = '0;
        exp[608 +: 32] = 32'hCAFE_BABE;
        run_store("after_abort", 8'h56, 2'd1, 6'd12, 32'hCAFE_BABE, 4'hF, exp);
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp_a;
        logic [LW-1:0] exp_b;
        cl_lines_in = {64{32'hA5A5_5A5A}}; ext_rd_op = 3'd0; ext_rd_idx = 8'h00;
        exp_a = {64{32'hA5A5_5A5A}};
        exp_a[992 +: 32] = 32'h1234_5678;
        exp_b = {64{32'hA5A5_5A5A}};
        exp_b[1568 +: 32] = 32'hCAA5_F05A;
        st_idx = 8'h21; st_way = 2'd1; st_offset = 6'd60; st_data = 32'h1234_5678; st_be = 4'hF;
        st_valid = 1'b1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a got=%b exp=1", st_ready); end
        tick();
        st_idx = 8'h22; st_way = 2'd3; st_offset = 6'd6; st_data = 32'hCAFE_F00D; st_be = 4'b1010;
        total++; if (ext_stall !== 1'b1 || ds_idx !== 8'h21) begin bad++; $display("FAIL b2b_read_a got=%b/%h exp=1/21", ext_stall, ds_idx); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_read got=%b exp=0", st_ready); end
        tick();
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_wait got=%b exp=0", st_ready); end
        tick();
        total++; if (alloc !== 1'b1 || idx_in_wb !== 8'h21) begin bad++; $display("FAIL b2b_write_a got=%b/%h exp=1/21", alloc, idx_in_wb); end
        total++; if (cl_in_wb !== exp_a) begin bad++; $display("FAIL b2b_line_a differing_bits=%0d exp=0", $countones(cl_in_wb ^ exp_a)); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_write got=%b exp=0", st_ready); end
        tick();
        total++; if (st_ready !== 1'b1 || alloc !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=1/0", st_ready, alloc); end
        tick();
        st_valid = 1'b0;
        total++; if (ext_stall !== 1'b1 || ds_idx !== 8'h22) begin bad++; $display("FAIL b2b_read_b got=%b/%h exp=1/22", ext_stall, ds_idx); end
        tick();
        tick();
        total++; if (alloc !== 1'b1 || idx_in_wb !== 8'h22) begin bad++; $display("FAIL b2b_write_b got=%b/%h exp=1/22", alloc, idx_in_wb); end
        total++; if (cl_in_wb !== exp_b) begin bad++; $display("FAIL b2b_line_b differing_bits=%0d exp=0", $countones(cl_in_wb ^ exp_b)); end
        tick();
        total++; if (st_ready !== 1'b1 || alloc !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%b exp=1/0", st_ready, alloc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_be_zero();
        test_ext_stall();
        test_fwd();
        test_reset_in_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
